// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
//   Frame = start bit, DATA_BITS data bits (LSB first), optional parity bit,
//   STOP_BITS stop bits; every bit lasts BAUD_DIV = MODULE_CLK_RATE /
//   UART_BAUDCLK_RATE clocks. Back-to-back frames leave no idle clocks.
//   Optional macro UART_TX_FIFO_EN: adds a FIFO_DEPTH-entry FIFO ahead of
//   the serializer (default build: direct handshake, fifo_count_o = 0).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   tx_valid_i      - producer has a word on tx_data_i
//   tx_data_i       - word to send
//   tx_ready_o      - word accepted on tx_valid_i & tx_ready_o
//   tx_busy_o       - frame in progress or word pending in the FIFO
//   tx_done_o       - one-cycle pulse after the last stop-bit clock
//   fifo_count_o    - FIFO occupancy (0 without the FIFO)
//   uart_tx         - registered serial line, idle high
module uart_tx_frame #(
    parameter int unsigned MODULE_CLK_RATE   = 100000000,
    parameter int unsigned UART_BAUDCLK_RATE = 115200,
    parameter int unsigned DATA_BITS         = 8,
    parameter int unsigned PARITY            = 0,
    parameter int unsigned STOP_BITS         = 1,
    parameter int unsigned FIFO_DEPTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid_i,
    input  logic [DATA_BITS-1:0]          tx_data_i,
    output logic                          tx_ready_o,
    output logic                          tx_busy_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          uart_tx
);
    localparam int unsigned BAUD_DIV = MODULE_CLK_RATE / UART_BAUDCLK_RATE;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Elaboration-time parameter legality
    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_frame: BAUD_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [FCNT_W-1:0]    count_q, count_d;
    logic                 bit_end, last_stop, load;
    logic [DATA_BITS-1:0] ld_data;
    logic                 ld_par;

    assign bit_end   = (cnt_q == CNT_W'(BAUD_DIV - 1));
    assign last_stop = (state_q == S_STOP) && bit_end
                       && (stop_idx_q == 1'(STOP_BITS - 1));
    // Odd parity inverts the XOR so that data+parity has an odd ones count
    assign ld_par    = (PARITY == 1) ? ~(^ld_data) : (^ld_data);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic                 push, pop;

    // Ready looks only at current occupancy: a pop in the same cycle does not free a slot
    assign tx_ready_o = ~rst & (count_q != FCNT_W'(FIFO_DEPTH));
    assign push       = tx_valid_i & tx_ready_o;
    assign pop        = (count_q != '0) & ((state_q == S_IDLE) | last_stop);
    assign load       = pop;
    assign ld_data    = mem_q[rd_ptr_q];

    // FIFO occupancy update
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // FIFO storage (no reset needed; guarded by occupancy)
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end
`else
    // Direct handshake: accept in IDLE or in the last clock of the last stop bit
    assign tx_ready_o = ~rst & ((state_q == S_IDLE) | last_stop);
    assign load       = tx_valid_i & tx_ready_o;
    assign ld_data    = tx_data_i;
    assign count_d    = '0;
`endif

    // Serializer next state; tx_d is the line value for the following cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (load) begin
                state_d = S_START;
                shift_d = ld_data;
                par_d   = ld_par;
                tx_d    = 1'b0;
            end
        end else begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                        tx_d      = shift_q[0];
                    end
                    S_DATA: begin
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            stop_idx_d = 1'b0;
                            if (PARITY != 0) begin
                                state_d = S_PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = S_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                            shift_d   = shift_q >> 1;
                            tx_d      = shift_q[1];
                        end
                    end
                    S_PARITY: begin
                        state_d    = S_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end
                    S_STOP: begin
                        if (!last_stop) begin
                            stop_idx_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            if (load) begin
                                state_d = S_START;
                                shift_d = ld_data;
                                par_d   = ld_par;
                                tx_d    = 1'b0;
                            end else begin
                                state_d = S_IDLE;
                                tx_d    = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                endcase
            end
        end
        busy_d = (state_d != S_IDLE) | (count_d != '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign uart_tx      = tx_q;
    assign tx_done_o    = done_q;
    assign tx_busy_o    = busy_q;
    assign fifo_count_o = count_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7E2) at BAUD_DIV=10.
`timescale 1ns/1ps
module tb_uart_tx_frame;
    localparam int NU   = 4;
    localparam int BAUD = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NU-1:0]   valid = '0;
    logic [7:0]      data [NU];
    wire  [NU-1:0]   ready, busy, done, line;
    wire  [4:0]      cnt [NU];

    always #5 clk = ~clk;

    uart_tx_frame #(.MODULE_CLK_RATE(100000000), .UART_BAUDCLK_RATE(10000000),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .tx_valid_i(valid[0]), .tx_data_i(data[0]),
        .tx_ready_o(ready[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]),
        .fifo_count_o(cnt[0]), .uart_tx(line[0]));
    uart_tx_frame #(.MODULE_CLK_RATE(100000000), .UART_BAUDCLK_RATE(10000000),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .tx_valid_i(valid[1]), .tx_data_i(data[1]),
        .tx_ready_o(ready[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]),
        .fifo_count_o(cnt[1]), .uart_tx(line[1]));
    uart_tx_frame #(.MODULE_CLK_RATE(100000000), .UART_BAUDCLK_RATE(10000000),
                    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .tx_valid_i(valid[2]), .tx_data_i(data[2]),
        .tx_ready_o(ready[2]), .tx_busy_o(busy[2]), .tx_done_o(done[2]),
        .fifo_count_o(cnt[2]), .uart_tx(line[2]));
    uart_tx_frame #(.MODULE_CLK_RATE(100000000), .UART_BAUDCLK_RATE(10000000),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
        .clk(clk), .rst(rst), .tx_valid_i(valid[3]), .tx_data_i(data[3][6:0]),
        .tx_ready_o(ready[3]), .tx_busy_o(busy[3]), .tx_done_o(done[3]),
        .fifo_count_o(cnt[3]), .uart_tx(line[3]));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-unit configuration
    function automatic int dbits(input int u);
        return (u == 3) ? 7 : 8;
    endfunction
    function automatic int pmode(input int u);
        case (u)
            1: return 2;
            2: return 1;
            3: return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int nstop(input int u);
        return (u == 3) ? 2 : 1;
    endfunction

    // Reference frame as a string of line bits in transmission order
    function automatic string build(input int u, input logic [7:0] d);
        string s;
        int    ones;
        s    = "0";
        ones = 0;
        for (int i = 0; i < dbits(u); i++) begin
            s    = {s, d[i] ? "1" : "0"};
            ones = ones + int'(d[i]);
        end
        if (pmode(u) == 1) s = {s, (ones % 2 == 0) ? "1" : "0"};
        if (pmode(u) == 2) s = {s, (ones % 2 == 1) ? "1" : "0"};
        for (int i = 0; i < nstop(u); i++) s = {s, "1"};
        return s;
    endfunction

    // Behavioural model: remaining clocks of the frame currently on the line
    string         fr   [NU];
    int            rem  [NU];
    int            flen [NU];
    logic [NU-1:0] done_pend = '0;
    logic [7:0]    dfix [NU];
    logic [NU-1:0] line_s, ready_s, done_s, busy_s;
    logic [4:0]    cnt_s [NU];

    function automatic logic exp_line(input int u);
        if (rem[u] == 0) return 1'b1;
        return fr[u].getc((flen[u] - rem[u]) / BAUD) == 8'h31;
    endfunction

    // One clock: sample/compare at negedge, drive inputs, update model after posedge
    task automatic cycle(input logic [NU-1:0] v, input logic r);
        @(negedge clk);
        cyc++;
        line_s  = line;
        ready_s = ready;
        done_s  = done;
        busy_s  = busy;
        for (int u = 0; u < NU; u++) cnt_s[u] = cnt[u];
`ifndef UART_TX_FIFO_EN
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("line u%0d c%0d", u, cyc), line[u], exp_line(u));
            chk($sformatf("ready u%0d c%0d", u, cyc), ready[u], !rst && rem[u] <= 1);
            chk($sformatf("done u%0d c%0d", u, cyc), done[u], done_pend[u]);
            chk($sformatf("busy u%0d c%0d", u, cyc), busy[u], rem[u] > 0);
            chk($sformatf("count u%0d c%0d", u, cyc), cnt[u], 0);
        end
`endif
        valid = v;
        rst   = r;
        for (int u = 0; u < NU; u++) data[u] = v[u] ? dfix[u] : 8'($urandom);
        @(posedge clk);
`ifndef UART_TX_FIFO_EN
        for (int u = 0; u < NU; u++) begin
            if (r) begin
                rem[u]       = 0;
                done_pend[u] = 1'b0;
            end else begin
                logic acc;
                acc          = v[u] && rem[u] <= 1;
                done_pend[u] = (rem[u] == 1);
                if (rem[u] > 0) rem[u]--;
                if (acc) begin
                    fr[u]   = build(u, dfix[u]);
                    flen[u] = fr[u].len() * BAUD;
                    rem[u]  = flen[u];
                end
            end
        end
`endif
    endtask

    typedef struct {
        int          unit;
        logic [7:0]  data;
        int          len;
        logic [15:0] bits;   // transmission order, first bit at [len-1]
    } vec_t;
    vec_t vt [9];

    logic [NU-1:0] rv;
    logic          rr;
    int            d1, d2, n;
    logic [7:0]    pushed [17];
    string         exps;

    initial begin
        for (int u = 0; u < NU; u++) begin
            rem[u]  = 0;
            flen[u] = 0;
            fr[u]   = "";
            dfix[u] = 8'h00;
            data[u] = 8'h00;
        end
        vt[0] = '{0, 8'hA5, 10, 16'b0101001011};
        vt[1] = '{1, 8'hA5, 11, 16'b01010010101};
        vt[2] = '{2, 8'hA5, 11, 16'b01010010111};
        vt[3] = '{3, 8'h41, 11, 16'b01000001011};
        vt[4] = '{0, 8'h00, 10, 16'b0000000001};
        vt[5] = '{0, 8'hFF, 10, 16'b0111111111};
        vt[6] = '{1, 8'h01, 11, 16'b01000000011};
        vt[7] = '{2, 8'h01, 11, 16'b01000000001};
        vt[8] = '{3, 8'h7F, 11, 16'b01111111111};

        // Reset state
        cycle('0, 1'b1);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("rst line u%0d", u), line_s[u], 1'b1);
            chk($sformatf("rst ready u%0d", u), ready_s[u], 1'b0);
            chk($sformatf("rst busy u%0d", u), busy_s[u], 1'b0);
            chk($sformatf("rst done u%0d", u), done_s[u], 1'b0);
            chk($sformatf("rst count u%0d", u), cnt_s[u], 0);
        end
        cycle('0, 1'b0);
        cycle('0, 1'b0);

`ifndef UART_TX_FIFO_EN
        // Table-driven single frames
        for (int i = 0; i < 9; i++) begin
            int u, nclk;
            u         = vt[i].unit;
            nclk      = vt[i].len * BAUD;
            dfix[u]   = vt[i].data;
            cycle(4'(1 << u), 1'b0);
            for (int k = 1; k <= nclk + 2; k++) begin
                logic eb;
                cycle('0, 1'b0);
                eb = (k <= nclk) ? vt[i].bits[vt[i].len - 1 - (k - 1) / BAUD] : 1'b1;
                chk($sformatf("vec%0d line k%0d", i, k), line_s[u], eb);
                chk($sformatf("vec%0d ready k%0d", i, k), ready_s[u], k >= nclk);
                chk($sformatf("vec%0d done k%0d", i, k), done_s[u], k == nclk + 1);
            end
        end

        // Back-to-back: 0x55 then 0xAA with valid held
        dfix[0] = 8'h55;
        cycle(4'b0001, 1'b0);
        dfix[0] = 8'hAA;
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 203; k++) begin
            cycle((k <= 100) ? 4'b0001 : 4'b0000, 1'b0);
            if (done_s[0]) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
            if (k == 100) chk("b2b stop bit", line_s[0], 1'b1);
            if (k == 101) chk("b2b gapless start", line_s[0], 1'b0);
        end
        chk("b2b first done", d1, 101);
        chk("b2b done spacing", d2 - d1, 100);

        // Reset at clock 37 of a frame on all units
        for (int u = 0; u < NU; u++) dfix[u] = 8'($urandom);
        cycle(4'b1111, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            cycle('0, (k == 37 || k == 38) ? 1'b1 : 1'b0);
            if (k >= 38) begin
                chk($sformatf("abort line k%0d", k), line_s, 4'b1111);
                chk($sformatf("abort done k%0d", k), done_s, 4'b0000);
                chk($sformatf("abort busy k%0d", k), busy_s, 4'b0000);
            end
            if (k == 38) chk("abort ready", ready_s, 4'b0000);
            if (k == 40) chk("after abort ready", ready_s, 4'b1111);
        end
        for (int k = 0; k < 120; k++) cycle('0, 1'b0);

        // Randomized traffic against the model
        for (n = 0; n < 3000; n++) begin
            for (int u = 0; u < NU; u++) begin
                rv[u]   = ($urandom_range(0, 3) != 0);
                dfix[u] = 8'($urandom);
            end
            rr = ($urandom_range(0, 799) == 0);
            cycle(rv, rr);
        end
        for (int k = 0; k < 130; k++) cycle('0, 1'b0);
`else
        // FIFO: 18 consecutive push attempts; the first word is popped after one
        // clock, so 17 are accepted and the FIFO holds 16 when ready drops.
        exps = "";
        for (int c = 1; c <= 18; c++) begin
            dfix[0] = 8'(c * 37 + 5);
            if (c <= 17) pushed[c - 1] = dfix[0];
            cycle(4'b0001, 1'b0);
            chk($sformatf("fifo ready c%0d", c), ready_s[0], c <= 17);
            if (c == 18) chk("fifo full count", cnt_s[0], 16);
        end
        for (int j = 0; j < 17; j++) exps = {exps, build(0, pushed[j])};
        for (int c = 19; c <= 3 + 1700 + 3; c++) begin
            logic eb;
            cycle('0, 1'b0);
            eb = (c >= 3 && c < 3 + 1700) ? (exps.getc((c - 3) / BAUD) == 8'h31) : 1'b1;
            chk($sformatf("fifo line c%0d", c), line_s[0], eb);
            chk($sformatf("fifo done c%0d", c), done_s[0],
                (c >= 103) && (c <= 3 + 1700) && ((c - 3) % 100 == 0));
            if (c >= 103 && c <= 1603 && (c - 3) % 100 == 0)
                chk($sformatf("fifo count c%0d", c), cnt_s[0], 15 - (c - 103) / 100);
        end
        chk("fifo drained busy", busy_s[0], 1'b0);
        chk("fifo drained count", cnt_s[0], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
